// File: rtl/per_req_buffer_pkg.sv
// Shared request/response payload types for the per_req_buffer slice.
package per_req_buffer_pkg;

  localparam int unsigned PER_ADDR_W = 32;
  localparam int unsigned PER_DATA_W = 32;
  localparam int unsigned PER_ID_W   = 5;
  localparam int unsigned PER_BE_W   = PER_DATA_W / 8;

  typedef struct packed {
    logic [PER_ADDR_W-1:0] add;
    logic                  wen;
    logic [PER_DATA_W-1:0] wdata;
    logic [PER_BE_W-1:0]   be;
    logic [PER_ID_W-1:0]   id;
  } per_req_t;

  typedef struct packed {
    logic                  opc;
    logic [PER_ID_W-1:0]   id;
    logic [PER_DATA_W-1:0] rdata;
  } per_resp_t;

endpackage

// File: rtl/per_req_fifo.sv
// Generic DEPTH-entry synchronous FIFO; pointers carry an extra wrap bit.
module per_req_fifo
  import per_req_buffer_pkg::*;
#(
  parameter type         T     = per_req_t,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  T            data_i,
  input  logic        pop_i,
  output T            data_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] level_o
);

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  T            mem_q [DEPTH];
  logic        do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign level_o = wptr_q - rptr_q;
  assign data_o  = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/per_req_buffer.sv
// Peripheral request buffer: request FIFO, outstanding cap, registered response.
// Optional zero-latency bypass when empty: define PER_REQ_BUFFER_FALLTHROUGH_EN.
module per_req_buffer
  import per_req_buffer_pkg::*;
#(
  parameter int unsigned PER_ADDR_WIDTH  = PER_ADDR_W,
  parameter int unsigned PER_DATA_WIDTH  = PER_DATA_W,
  parameter int unsigned PER_ID_WIDTH    = PER_ID_W,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        slv_req_i,
  input  logic [PER_ADDR_WIDTH-1:0]   slv_add_i,
  input  logic                        slv_wen_i,
  input  logic [PER_DATA_WIDTH-1:0]   slv_wdata_i,
  input  logic [PER_DATA_WIDTH/8-1:0] slv_be_i,
  input  logic [PER_ID_WIDTH-1:0]     slv_id_i,
  output logic                        slv_gnt_o,
  output logic                        slv_r_valid_o,
  output logic                        slv_r_opc_o,
  output logic [PER_ID_WIDTH-1:0]     slv_r_id_o,
  output logic [PER_DATA_WIDTH-1:0]   slv_r_rdata_o,
  output logic                        mst_req_o,
  output logic [PER_ADDR_WIDTH-1:0]   mst_add_o,
  output logic                        mst_wen_o,
  output logic [PER_DATA_WIDTH-1:0]   mst_wdata_o,
  output logic [PER_DATA_WIDTH/8-1:0] mst_be_o,
  output logic [PER_ID_WIDTH-1:0]     mst_id_o,
  input  logic                        mst_gnt_i,
  input  logic                        mst_r_valid_i,
  input  logic                        mst_r_opc_i,
  input  logic [PER_ID_WIDTH-1:0]     mst_r_id_i,
  input  logic [PER_DATA_WIDTH-1:0]   mst_r_rdata_i,
  output logic                        busy_o,
  output logic                        err_underflow_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] MAX_OUT = CW'(MAX_OUTSTANDING);

  per_req_t  slv_pl, head, mst_pl;
  per_resp_t resp_q, resp_d;
  logic      full, empty, push, pop, accept, rsp_dec;
  logic [LW-1:0] level, level_d;
  logic [CW-1:0] out_q, out_d;
  logic      r_valid_q, busy_q, busy_d, err_q, err_d;

  assign slv_pl = '{add: slv_add_i, wen: slv_wen_i, wdata: slv_wdata_i, be: slv_be_i, id: slv_id_i};

  per_req_fifo #(.T(per_req_t), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (slv_pl),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  assign slv_gnt_o = !full && (out_q < MAX_OUT);
  assign accept    = slv_req_i && slv_gnt_o;

  always_comb begin
    mst_req_o = !empty;
    mst_pl    = empty ? '0 : head;
    push      = accept;
    pop       = !empty && mst_gnt_i;
`ifdef PER_REQ_BUFFER_FALLTHROUGH_EN
    // Bypass only when empty so ordering with queued entries is preserved.
    if (empty) begin
      mst_req_o = accept;
      mst_pl    = slv_pl;
      push      = accept && !mst_gnt_i;
    end
`endif
  end

  assign mst_add_o   = mst_pl.add;
  assign mst_wen_o   = mst_pl.wen;
  assign mst_wdata_o = mst_pl.wdata;
  assign mst_be_o    = mst_pl.be;
  assign mst_id_o    = mst_pl.id;

  assign rsp_dec = mst_r_valid_i && (out_q != '0);
  assign level_d = level + LW'(push) - LW'(pop);

  always_comb begin
    out_d  = out_q;
    err_d  = err_q;
    resp_d = resp_q;
    if (mst_r_valid_i && (out_q == '0)) err_d = 1'b1;
    if (accept && !rsp_dec)      out_d = out_q + 1'b1;
    else if (!accept && rsp_dec) out_d = out_q - 1'b1;
    if (mst_r_valid_i) resp_d = '{opc: mst_r_opc_i, id: mst_r_id_i, rdata: mst_r_rdata_i};
    busy_d = (out_d != '0) || (level_d != '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q     <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      r_valid_q <= 1'b0;
      resp_q    <= '0;
    end else begin
      out_q     <= out_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      r_valid_q <= mst_r_valid_i;
      resp_q    <= resp_d;
    end
  end

  assign slv_r_valid_o   = r_valid_q;
  assign slv_r_opc_o     = resp_q.opc;
  assign slv_r_id_o      = resp_q.id;
  assign slv_r_rdata_o   = resp_q.rdata;
  assign busy_o          = busy_q;
  assign err_underflow_o = err_q;

endmodule

// File: tb/tb_per_req_buffer.sv
// Directed self-checking bench for per_req_buffer (DEPTH=4, MAX_OUTSTANDING=8).
module tb_per_req_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        slv_req, slv_wen, slv_gnt, slv_r_valid, slv_r_opc;
  logic [31:0] slv_add, slv_wdata, slv_r_rdata;
  logic [3:0]  slv_be;
  logic [4:0]  slv_id, slv_r_id;
  logic        mst_req, mst_wen, mst_gnt, mst_r_valid, mst_r_opc;
  logic [31:0] mst_add, mst_wdata, mst_r_rdata;
  logic [3:0]  mst_be;
  logic [4:0]  mst_id, mst_r_id;
  logic        busy, err_uf;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  per_req_buffer #(
    .PER_ADDR_WIDTH(32), .PER_DATA_WIDTH(32), .PER_ID_WIDTH(5),
    .DEPTH(4), .MAX_OUTSTANDING(8)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .slv_req_i(slv_req), .slv_add_i(slv_add), .slv_wen_i(slv_wen),
    .slv_wdata_i(slv_wdata), .slv_be_i(slv_be), .slv_id_i(slv_id),
    .slv_gnt_o(slv_gnt), .slv_r_valid_o(slv_r_valid), .slv_r_opc_o(slv_r_opc),
    .slv_r_id_o(slv_r_id), .slv_r_rdata_o(slv_r_rdata),
    .mst_req_o(mst_req), .mst_add_o(mst_add), .mst_wen_o(mst_wen),
    .mst_wdata_o(mst_wdata), .mst_be_o(mst_be), .mst_id_o(mst_id),
    .mst_gnt_i(mst_gnt), .mst_r_valid_i(mst_r_valid), .mst_r_opc_i(mst_r_opc),
    .mst_r_id_i(mst_r_id), .mst_r_rdata_i(mst_r_rdata),
    .busy_o(busy), .err_underflow_o(err_uf)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    mst_r_valid = 1'b1; mst_r_id = '0; mst_r_rdata = '0; mst_r_opc = 1'b0;
    repeat (n) tick;
    mst_r_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; tick; tick; rst = 1'b0;
    vectors++; if (slv_gnt !== 1'b1) begin miscompares++; $display("FAIL reset_gnt: got %b expected 1", slv_gnt); end
    vectors++; if (mst_req !== 1'b0) begin miscompares++; $display("FAIL reset_mst_req: got %b expected 0", mst_req); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (slv_r_valid !== 1'b0) begin miscompares++; $display("FAIL reset_r_valid: got %b expected 0", slv_r_valid); end
    vectors++; if (err_uf !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", err_uf); end
    vectors++; if (slv_r_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h expected 0", slv_r_rdata); end
    vectors++; if (mst_add !== 32'h0) begin miscompares++; $display("FAIL reset_mst_add: got %h expected 0", mst_add); end
  endtask

  task automatic test_single_read;
    mst_gnt = 1'b1;
    slv_req = 1'b1; slv_add = 32'h1000_0010; slv_wen = 1'b1; slv_id = 5'd3; slv_be = 4'hF; slv_wdata = '0;
    vectors++; if (slv_gnt !== 1'b1) begin miscompares++; $display("FAIL read_gnt: got %b expected 1", slv_gnt); end
`ifdef PER_REQ_BUFFER_FALLTHROUGH_EN
    vectors++; if (mst_req !== 1'b1 || mst_add !== 32'h1000_0010) begin miscompares++; $display("FAIL read_bypass: got req=%b add=%h expected req=1 add=10000010", mst_req, mst_add); end
    tick; slv_req = 1'b0;
    vectors++; if (mst_req !== 1'b0) begin miscompares++; $display("FAIL read_bypass_done: got %b expected 0", mst_req); end
`else
    vectors++; if (mst_req !== 1'b0) begin miscompares++; $display("FAIL read_latency: got %b expected 0", mst_req); end
    tick; slv_req = 1'b0;
    vectors++; if (mst_req !== 1'b1) begin miscompares++; $display("FAIL read_mst_req: got %b expected 1", mst_req); end
    vectors++; if (mst_add !== 32'h1000_0010) begin miscompares++; $display("FAIL read_mst_add: got %h expected 10000010", mst_add); end
    vectors++; if (mst_id !== 5'd3 || mst_wen !== 1'b1) begin miscompares++; $display("FAIL read_mst_id: got id=%0d wen=%b expected id=3 wen=1", mst_id, mst_wen); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL read_busy_q: got %b expected 1", busy); end
    tick;
    vectors++; if (mst_req !== 1'b0) begin miscompares++; $display("FAIL read_popped: got %b expected 0", mst_req); end
`endif
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL read_busy_out: got %b expected 1", busy); end
    mst_r_valid = 1'b1; mst_r_rdata = 32'hDEAD_BEEF; mst_r_id = 5'd3; mst_r_opc = 1'b0;
    tick; mst_r_valid = 1'b0;
    vectors++; if (slv_r_valid !== 1'b1) begin miscompares++; $display("FAIL read_r_valid: got %b expected 1", slv_r_valid); end
    vectors++; if (slv_r_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL read_rdata: got %h expected deadbeef", slv_r_rdata); end
    vectors++; if (slv_r_id !== 5'd3 || slv_r_opc !== 1'b0) begin miscompares++; $display("FAIL read_r_id: got id=%0d opc=%b expected id=3 opc=0", slv_r_id, slv_r_opc); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL read_busy_idle: got %b expected 0", busy); end
    tick;
    vectors++; if (slv_r_valid !== 1'b0) begin miscompares++; $display("FAIL read_r_pulse: got %b expected 0", slv_r_valid); end
  endtask

  task automatic test_full_fifo;
    mst_gnt = 1'b0;
    for (int i = 0; i < 6; i++) begin
      slv_req = 1'b1; slv_wen = 1'b0; slv_id = 5'(i); slv_add = 32'h2000 + 32'(4 * i); slv_wdata = 32'hA0 + 32'(i);
      vectors++; if (slv_gnt !== (i < 4)) begin miscompares++; $display("FAIL full_gnt[%0d]: got %b expected %b", i, slv_gnt, (i < 4)); end
      tick;
    end
    slv_req = 1'b0;
    vectors++; if (slv_gnt !== 1'b0) begin miscompares++; $display("FAIL full_gnt_held: got %b expected 0", slv_gnt); end
    vectors++; if (mst_req !== 1'b1 || mst_id !== 5'd0) begin miscompares++; $display("FAIL full_head: got req=%b id=%0d expected req=1 id=0", mst_req, mst_id); end
    tick;
    vectors++; if (mst_id !== 5'd0 || mst_add !== 32'h2000 || mst_wdata !== 32'hA0) begin miscompares++; $display("FAIL full_stable: got id=%0d add=%h wdata=%h expected id=0 add=2000 wdata=a0", mst_id, mst_add, mst_wdata); end
    mst_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++; if (mst_req !== 1'b1 || mst_id !== 5'(i) || mst_add !== 32'h2000 + 32'(4 * i) || mst_wen !== 1'b0) begin
        miscompares++; $display("FAIL full_pop[%0d]: got req=%b id=%0d add=%h wen=%b expected req=1 id=%0d add=%h wen=0", i, mst_req, mst_id, mst_add, mst_wen, i, 32'h2000 + 32'(4 * i));
      end
      tick;
    end
    vectors++; if (mst_req !== 1'b0) begin miscompares++; $display("FAIL full_empty: got %b expected 0", mst_req); end
    drain(4);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL full_busy_idle: got %b expected 0", busy); end
  endtask

  task automatic test_outstanding_cap;
    mst_gnt = 1'b1; slv_wen = 1'b1;
    for (int i = 0; i < 8; i++) begin
      slv_req = 1'b1; slv_id = 5'(i);
      vectors++; if (slv_gnt !== 1'b1) begin miscompares++; $display("FAIL cap_gnt[%0d]: got %b expected 1", i, slv_gnt); end
      tick;
    end
    tick; tick;
    vectors++; if (slv_gnt !== 1'b0 || mst_req !== 1'b0) begin miscompares++; $display("FAIL cap_blocked: got gnt=%b req=%b expected gnt=0 req=0", slv_gnt, mst_req); end
    mst_r_valid = 1'b1; mst_r_id = '0; tick; mst_r_valid = 1'b0;
    vectors++; if (slv_gnt !== 1'b1) begin miscompares++; $display("FAIL cap_regrant: got %b expected 1", slv_gnt); end
    tick;
    vectors++; if (slv_gnt !== 1'b0) begin miscompares++; $display("FAIL cap_one_more: got %b expected 0", slv_gnt); end
    slv_req = 1'b0;
    tick; tick;
    drain(8);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL cap_busy_idle: got %b expected 0", busy); end
  endtask

  task automatic test_same_cycle;
    int grants;
    mst_gnt = 1'b1;
    slv_req = 1'b1;
    repeat (5) tick;
    slv_req = 1'b0; tick; tick;
    slv_req = 1'b1; mst_r_valid = 1'b1; mst_r_id = 5'd9;
    tick;
    slv_req = 1'b0; mst_r_valid = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL same_busy: got %b expected 1", busy); end
    tick; tick;
    grants = 0;
    slv_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (slv_gnt === 1'b1) grants++;
      tick;
    end
    slv_req = 1'b0;
    vectors++; if (grants !== 3) begin miscompares++; $display("FAIL same_count: got %0d further grants expected 3", grants); end
    tick; tick;
    drain(8);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL same_busy_idle: got %b expected 0", busy); end
  endtask

  task automatic test_underflow;
    mst_r_valid = 1'b1; mst_r_id = 5'd7; mst_r_rdata = 32'h1234_5678; mst_r_opc = 1'b1;
    tick; mst_r_valid = 1'b0;
    vectors++; if (slv_r_valid !== 1'b1 || slv_r_id !== 5'd7 || slv_r_rdata !== 32'h1234_5678 || slv_r_opc !== 1'b1) begin
      miscompares++; $display("FAIL uf_forward: got v=%b id=%0d rdata=%h opc=%b expected v=1 id=7 rdata=12345678 opc=1", slv_r_valid, slv_r_id, slv_r_rdata, slv_r_opc);
    end
    vectors++; if (err_uf !== 1'b1) begin miscompares++; $display("FAIL uf_err: got %b expected 1", err_uf); end
    vectors++; if (busy !== 1'b0 || slv_gnt !== 1'b1) begin miscompares++; $display("FAIL uf_counter: got busy=%b gnt=%b expected busy=0 gnt=1", busy, slv_gnt); end
    tick; tick;
    vectors++; if (err_uf !== 1'b1 || slv_r_valid !== 1'b0) begin miscompares++; $display("FAIL uf_sticky: got err=%b v=%b expected err=1 v=0", err_uf, slv_r_valid); end
  endtask

  task automatic test_reset_mid;
    mst_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      slv_req = 1'b1; slv_id = 5'(i); tick;
    end
    slv_req = 1'b0;
    vectors++; if (busy !== 1'b1 || mst_req !== 1'b1) begin miscompares++; $display("FAIL mid_queued: got busy=%b req=%b expected busy=1 req=1", busy, mst_req); end
    rst = 1'b1; tick; rst = 1'b0;
    vectors++; if (mst_req !== 1'b0 || busy !== 1'b0 || slv_gnt !== 1'b1) begin miscompares++; $display("FAIL mid_reset: got req=%b busy=%b gnt=%b expected req=0 busy=0 gnt=1", mst_req, busy, slv_gnt); end
    vectors++; if (err_uf !== 1'b0) begin miscompares++; $display("FAIL mid_err_clear: got %b expected 0", err_uf); end
    mst_r_valid = 1'b1; mst_r_id = 5'd1; tick; mst_r_valid = 1'b0;
    vectors++; if (err_uf !== 1'b1 || slv_r_valid !== 1'b1) begin miscompares++; $display("FAIL mid_late_rsp: got err=%b v=%b expected err=1 v=1", err_uf, slv_r_valid); end
  endtask

  initial begin
    rst = 1'b1; slv_req = 1'b0; slv_add = '0; slv_wen = 1'b0; slv_wdata = '0; slv_be = '0; slv_id = '0;
    mst_gnt = 1'b0; mst_r_valid = 1'b0; mst_r_opc = 1'b0; mst_r_id = '0; mst_r_rdata = '0;
    tick;
    test_reset;
    test_single_read;
    test_full_fifo;
    test_outstanding_cap;
    test_same_cycle;
    test_underflow;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
